bram_uart_dump_ctrl: RTL
========================

// Module: bram_uart_dump_ctrl
// PURPOSE
//  Sequencer that streams a block of BRAM words out through the 8-bit UART transmitter.
//  On a start pulse it reads LEN words from BASE_ADDR and splits each word into bytes, MSB byte first.
//  Each byte is handed to the UART TX using its req/busy handshake.
//  Sits between the BRAM read port and the UART TX instance; it is the only driver of the TX din/req pins.
// PARAMETERS
//  ADDR_W    10  BRAM address width; the address wraps modulo 2^ADDR_W
//  DATA_W    32  BRAM word width; must be a multiple of 8; BPW = DATA_W/8 bytes per word
//  BRAM_LAT  1   BRAM read latency in cycles from bram_en to valid bram_dout (1..3)
// PORTS
//  CLK_50M    in   1       system clock, 50 MHz
//  rst_n      in   1       asynchronous reset, active-low
//  start      in   1       1-cycle pulse; ignored unless active==0
//  base_addr  in   ADDR_W  first word address; sampled on start
//  len        in   ADDR_W+1  number of words to send; sampled on start
//  abort      in   1       level; stop at the next byte boundary
//  bram_en    out  1       BRAM read enable; 1-cycle pulse per word
//  bram_addr  out  ADDR_W  BRAM read address
//  bram_dout  in   DATA_W  BRAM read data
//  tx_din     out  8       byte to UART TX; held stable from the req cycle until busy falls
//  tx_req     out  1       1-cycle request to UART TX
//  tx_busy    in   1       UART TX busy; rises the cycle after req and falls after the stop bit
//  active     out  1       high from the cycle after start until the done cycle, inclusive
//  done       out  1       1-cycle pulse at the end of a transfer (normal or aborted)
//  aborted    out  1       valid with done; 1 if the transfer ended early because of abort
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; tx_din 8'h00.
//  FSM states and transitions:
//   IDLE -> RD on start (len!=0); IDLE -> FIN on start with len==0 (done 1 cycle later, no req).
//   RD: assert bram_en for 1 cycle at addr, then wait BRAM_LAT cycles -> LOAD.
//   LOAD: capture bram_dout into a shift register; byte_idx=0 -> SEND.
//   SEND: tx_din=word[DATA_W-1-8*byte_idx -: 8]; tx_req=1 for exactly 1 cycle -> WAIT_HI.
//   WAIT_HI: wait for tx_busy==1. If busy is not seen within 4 cycles -> FIN with aborted=1.
//   WAIT_LO: wait for tx_busy==0, then -> NEXT.
//   NEXT: order of checks:
//    1. abort==1 -> FIN with aborted=1.
//    2. byte_idx<BPW-1 -> byte_idx++, go to SEND.
//    3. word count < len -> addr++ (wraps), go to RD.
//    4. Otherwise -> CHK (if enabled) or FIN.
//   FIN: done=1 for 1 cycle, aborted valid -> IDLE.
//  abort in IDLE/RD/LOAD: go to FIN immediately with aborted=1.
//  abort in SEND/WAIT_*: the in-flight UART frame is never truncated.
//  start while active: ignored, with no effect on sampled base_addr/len.
//  Minimum byte spacing: 1 UART frame + 2 cycles (NEXT, SEND).
//  No req is issued while tx_busy==1.
//  Reset mid-transfer: immediate return to IDLE; tx_req=0; no done pulse.
//  len==2^ADDR_W: every address is read once, starting at base_addr and wrapping.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//   - An 8-bit running sum (mod 256) of every byte sent is kept, cleared on start.
//   - After the last data byte, CHK sends ~sum+1 (two's complement) as one extra byte.
//   - The CHK byte uses the same handshake, then -> FIN.
//   - If abort ends the transfer, the CHK byte is not sent.
//  DUMP_CHECKSUM_EN undefined: no CHK state, no accumulator; the last data byte goes straight to FIN.
// STRUCTURE
//  Package dump_ctrl_pkg:
//   - FSM state encoding localparams.
//   - BPW derivation.
//   - WAIT_HI timeout constant (4).
//  Sub-module tx_byte_handshake:
//   - Handles SEND/WAIT_HI/WAIT_LO for one byte.
//   - Ports: go, byte_in, tx_req, tx_din, tx_busy, byte_done, timeout.
//   - The top FSM handles addressing, word splitting, abort and checksum.
// TESTING
//  UART TX model: busy rises 1 cycle after req, stays high for 20 cycles.
//  1. base=0x010, len=2, BRAM[0x010]=0x11223344, BRAM[0x011]=0xA5A5_0F0F
//     -> tx bytes 11,22,33,44,A5,A5,0F,0F in order; one done, aborted=0.
//  2. len=0 -> done 2 cycles after start, aborted=0, zero tx_req pulses, zero bram_en pulses.
//  3. base=0x3FF, len=2 -> bram_addr sequence 0x3FF, 0x000 (wrap).
//  4. abort raised during byte 2 of 8
//     -> byte 2 frame completes; done with aborted=1; exactly 2 req pulses.
//  5. start re-pulsed mid-transfer with base=0x100 -> ignored; addresses unchanged; a single done.
//  6. DUMP_CHECKSUM_EN, bytes 01,02,03,04 -> 5th byte 0xF6.
//     With the macro undefined, exactly 4 bytes are sent.
//     Also: reset mid-WAIT_LO -> tx_req=0, active=0, no done.

Source files
------------

// File: rtl/bram_uart_dump_ctrl_pkg.sv
// Shared definitions for the BRAM-to-UART dump sequencer.
//   - Top-level FSM state encoding
//   - Byte-handshake sub-FSM encoding
//   - Bytes-per-word helper and the WAIT_HI busy timeout
// Optional feature macro: DUMP_CHECKSUM_EN (adds the CHK / CHK_WAIT states).
package dump_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_RD       = 4'd1;
    localparam state_t ST_LOAD     = 4'd2;
    localparam state_t ST_SEND     = 4'd3;
    localparam state_t ST_WAIT_TX  = 4'd4;
    localparam state_t ST_NEXT     = 4'd5;
    localparam state_t ST_FIN      = 4'd6;
`ifdef DUMP_CHECKSUM_EN
    localparam state_t ST_CHK      = 4'd7;
    localparam state_t ST_CHK_WAIT = 4'd8;
`endif

    typedef logic [1:0] hs_state_t;

    localparam hs_state_t HS_IDLE    = 2'd0;
    localparam hs_state_t HS_WAIT_HI = 2'd1;
    localparam hs_state_t HS_WAIT_LO = 2'd2;

    // Cycles allowed for tx_busy to rise after a request.
    localparam int WAIT_HI_TIMEOUT = 4;

    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bram_uart_dump_ctrl_tx_byte_handshake.sv
// tx_byte_handshake: sends one byte through the UART TX req/busy handshake.
//   CLK_50M, rst_n : clock, async active-low reset
//   go             : request to send byte_in (only honoured when idle)
//   byte_in        : byte to send
//   tx_req, tx_din : UART TX request pulse and data (data held until busy falls)
//   tx_busy        : UART TX busy
//   byte_done      : 1-cycle pulse when busy has fallen after the frame
//   timeout        : 1-cycle pulse when busy never rose within WAIT_HI_TIMEOUT cycles
//
// state      | meaning
// HS_IDLE    | no frame in flight; go issues tx_req in the same cycle
// HS_WAIT_HI | request issued, waiting for tx_busy to rise
// HS_WAIT_LO | frame in flight, waiting for tx_busy to fall
module tx_byte_handshake
    import dump_ctrl_pkg::*;
(
    input  logic       CLK_50M,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] byte_in,
    output logic       tx_req,
    output logic [7:0] tx_din,
    input  logic       tx_busy,
    output logic       byte_done,
    output logic       timeout
);

    localparam logic [2:0] TO_LOAD = 3'(WAIT_HI_TIMEOUT);

    hs_state_t  hs_q, hs_d;
    logic [7:0] din_q;
    logic [2:0] to_cnt_q;

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) hs_q <= HS_IDLE;
        else        hs_q <= hs_d;
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            din_q    <= 8'h00;
            to_cnt_q <= 3'd0;
        end else begin
            if (tx_req) begin
                din_q    <= byte_in;
                to_cnt_q <= TO_LOAD;
            end else if (hs_q == HS_WAIT_HI && to_cnt_q != 3'd0) begin
                to_cnt_q <= to_cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        hs_d = hs_q;
        case (hs_q)
            HS_IDLE:    if (go) hs_d = HS_WAIT_HI;
            HS_WAIT_HI: begin
                if (tx_busy)               hs_d = HS_WAIT_LO;
                else if (to_cnt_q == 3'd1) hs_d = HS_IDLE;
            end
            HS_WAIT_LO: if (!tx_busy) hs_d = HS_IDLE;
            default:    hs_d = HS_IDLE;
        endcase
    end

    // The request cycle drives byte_in directly so data and req line up;
    // afterwards the captured copy holds the pins stable.
    always_comb begin
        tx_req    = (hs_q == HS_IDLE) && go;
        tx_din    = tx_req ? byte_in : din_q;
        byte_done = (hs_q == HS_WAIT_LO) && !tx_busy;
        timeout   = (hs_q == HS_WAIT_HI) && !tx_busy && (to_cnt_q == 3'd1);
    end

endmodule

// File: rtl/bram_uart_dump_ctrl.sv
// bram_uart_dump_ctrl: reads len words from BRAM starting at base_addr and
// streams them MSB byte first through the UART TX req/busy handshake.
//   CLK_50M, rst_n      : clock, async active-low reset
//   start, base_addr,len: transfer request (sampled only when not active)
//   abort               : stop at the next byte boundary
//   bram_en, bram_addr, bram_dout : BRAM read port
//   tx_din, tx_req, tx_busy       : UART TX handshake
//   active, done, aborted         : status
// Optional feature macro: DUMP_CHECKSUM_EN appends a two's-complement checksum byte.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_RD       | bram_en pulse, then wait out the BRAM read latency
// ST_LOAD     | capture the BRAM word
// ST_SEND     | issue the current byte to the handshake
// ST_WAIT_TX  | byte frame in flight
// ST_NEXT     | abort / next byte / next word / finish decision
// ST_CHK      | issue checksum byte (DUMP_CHECKSUM_EN only)
// ST_CHK_WAIT | checksum frame in flight (DUMP_CHECKSUM_EN only)
// ST_FIN      | end of transfer; done pulses the following cycle
module bram_uart_dump_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int BRAM_LAT = 1
) (
    input  logic              CLK_50M,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [7:0]        tx_din,
    output logic              tx_req,
    input  logic              tx_busy,
    output logic              active,
    output logic              done,
    output logic              aborted
);

    localparam int         BPW      = bpw(DATA_W);
    localparam int         BI_W     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [1:0] LAT_LOAD = 2'(BRAM_LAT);

    state_t              state_q, state_d;
    logic                fin_abort;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     wcnt_q;
    logic [DATA_W-1:0]   word_q;
    logic [BI_W-1:0]     byte_idx_q;
    logic [1:0]          lat_cnt_q;
    logic                abort_flag_q;
    logic                done_q;
    logic                aborted_q;
    logic                go;
    logic [7:0]          byte_in;
    logic                byte_done;
    logic                timeout;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fin_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q high means we are still in the done cycle (active=1)
                if (start && !done_q) begin
                    if (abort) begin
                        state_d   = ST_FIN;
                        fin_abort = 1'b1;
                    end else if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (abort) begin
                    state_d   = ST_FIN;
                    fin_abort = 1'b1;
                end else if (lat_cnt_q == 2'd1) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_FIN;
                    fin_abort = 1'b1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (timeout) begin
                    state_d   = ST_FIN;
                    fin_abort = 1'b1;
                end else if (byte_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_d   = ST_FIN;
                    fin_abort = 1'b1;
                end else if (byte_idx_q != BI_W'(BPW - 1)) begin
                    state_d = ST_SEND;
                end else if (wcnt_q < len_q) begin
                    state_d = ST_RD;
                end else begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHK: state_d = ST_CHK_WAIT;
            ST_CHK_WAIT: begin
                if (timeout) begin
                    state_d   = ST_FIN;
                    fin_abort = 1'b1;
                end else if (byte_done) begin
                    state_d = ST_FIN;
                end
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            wcnt_q       <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            lat_cnt_q    <= 2'd0;
            abort_flag_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            done_q    <= (state_q == ST_FIN);
            aborted_q <= (state_q == ST_FIN) && abort_flag_q;

            if (state_q == ST_IDLE && state_d != ST_IDLE) begin
                addr_q <= base_addr;
                len_q  <= len;
                wcnt_q <= '0;
`ifdef DUMP_CHECKSUM_EN
                sum_q  <= 8'h00;
`endif
            end

            if (state_d == ST_FIN && state_q != ST_FIN)
                abort_flag_q <= fin_abort;

            // Latency down-counter is loaded on entry to RD.
            if (state_d == ST_RD && state_q != ST_RD)
                lat_cnt_q <= LAT_LOAD;
            else if (state_q == ST_RD && lat_cnt_q != 2'd0)
                lat_cnt_q <= lat_cnt_q - 2'd1;

            if (state_q == ST_LOAD) begin
                word_q     <= bram_dout;
                byte_idx_q <= '0;
                wcnt_q     <= wcnt_q + 1'b1;
            end

            if (state_q == ST_NEXT && state_d == ST_SEND) begin
                byte_idx_q <= byte_idx_q + 1'b1;
                word_q     <= word_q << 8;
            end

            if (state_q == ST_NEXT && state_d == ST_RD)
                addr_q <= addr_q + ADDR_W'(1);

`ifdef DUMP_CHECKSUM_EN
            if (state_q == ST_SEND)
                sum_q <= sum_q + word_q[DATA_W-1 -: 8];
`endif
        end
    end

    always_comb begin
        bram_en   = (state_q == ST_RD) && (lat_cnt_q == LAT_LOAD);
        bram_addr = addr_q;
        active    = (state_q != ST_IDLE) || done_q;
        done      = done_q;
        aborted   = aborted_q;
        go        = (state_q == ST_SEND);
        byte_in   = word_q[DATA_W-1 -: 8];
`ifdef DUMP_CHECKSUM_EN
        if (state_q == ST_CHK) begin
            go      = 1'b1;
            byte_in = ~sum_q + 8'd1;
        end
`endif
    end

    tx_byte_handshake u_tx_hs (
        .CLK_50M   (CLK_50M),
        .rst_n     (rst_n),
        .go        (go),
        .byte_in   (byte_in),
        .tx_req    (tx_req),
        .tx_din    (tx_din),
        .tx_busy   (tx_busy),
        .byte_done (byte_done),
        .timeout   (timeout)
    );

endmodule
